terrain_crater: RTL

TERRAIN_CRATER -- requirements
Module: terrain_crater

---
 rtl/terrain_pkg.sv | 10 +
 rtl/terrain_col_mask.sv | 22 ++
 rtl/terrain_crater.sv | 119 +++++++++++
 3 files changed

// File: rtl/terrain_pkg.sv
// terrain_pkg: shared terrain geometry constants and the crater FSM state type.
//   NCOLS  - number of terrain columns
//   NROWS  - rows per column; row NROWS-1 is the floor
//   COL_W  - width of one SRAM column word (bit i = row i, 1 = ground)
package terrain_pkg;
    localparam int NCOLS = 640;
    localparam int NROWS = 480;
    localparam int COL_W = 512;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_SRCH, S_WR, S_DONE} crater_state_e;
endpackage

// File: rtl/terrain_col_mask.sv
// terrain_col_mask: combinational row mask for one crater column.
//   cy_i   [9:0]        crater centre row
//   h_i    [5:0]        half-height of the cut in this column
//   mask_o [COL_W-1:0]  bit i set iff cy-h <= i <= cy+h and i < ROWS
module terrain_col_mask
    import terrain_pkg::*;
#(
    parameter int ROWS = NROWS
) (
    input  logic [9:0]       cy_i,
    input  logic [5:0]       h_i,
    output logic [COL_W-1:0] mask_o
);
    // 12-bit signed so cy+h never wraps and cy-h may go negative
    logic signed [11:0] lo, hi;
    assign lo = $signed({2'b0, cy_i}) - $signed({6'b0, h_i});
    assign hi = $signed({2'b0, cy_i}) + $signed({6'b0, h_i});
    for (genvar i = 0; i < COL_W; i++) begin : g_row
        localparam logic signed [11:0] ROW = 12'(i);
        assign mask_o[i] = (i < ROWS) && (lo <= ROW) && (ROW <= hi);
    end
endmodule

// File: rtl/terrain_crater.sv
// terrain_crater: carves a circular crater into a column-organised terrain SRAM,
// one read-modify-write per affected column.
//   clk, reset                 clock, asynchronous active-high reset
//   start                      one-cycle carve request (accepted only when idle)
//   center_x, center_y, radius crater geometry, latched on accepted start
//   rd_addr / rd_data          SRAM read port (data one cycle after address)
//   wr_addr / wr_data / we     SRAM write port, one write per column
//   busy, done                 operation in progress / one-cycle completion pulse
//   cleared_count              ground pixels removed (only with TERRAIN_CRATER_COUNT_EN)
module terrain_crater
    import terrain_pkg::*;
#(
    parameter int NCOLS = terrain_pkg::NCOLS,
    parameter int NROWS = terrain_pkg::NROWS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [9:0]       center_x,
    input  logic [9:0]       center_y,
    input  logic [5:0]       radius,
    output logic [9:0]       rd_addr,
    input  logic [COL_W-1:0] rd_data,
    output logic [9:0]       wr_addr,
    output logic [COL_W-1:0] wr_data,
    output logic             we,
    output logic             busy,
    output logic             done
`ifdef TERRAIN_CRATER_COUNT_EN
    ,output logic [15:0]     cleared_count
`endif
);
    localparam logic signed [11:0] HI_MAX = 12'(NCOLS - 1);

    crater_state_e      state_q, state_d;
    logic [9:0]         x_q, hi_q, cx_q, cy_q, dx;
    logic [5:0]         r_q, h_q;
    logic [COL_W-1:0]   col_q, wr_q, mask;
    logic signed [11:0] lo_raw, hi_raw, lo, hi;
    logic               gt;

    assign lo_raw = $signed({2'b0, center_x}) - $signed({6'b0, radius});
    assign hi_raw = $signed({2'b0, center_x}) + $signed({6'b0, radius});
    assign lo     = (lo_raw < 0) ? '0 : lo_raw;
    assign hi     = (hi_raw > HI_MAX) ? HI_MAX : hi_raw;

    // dx never exceeds r inside the column range, so h settles at or above 0
    assign dx = (x_q >= cx_q) ? x_q - cx_q : cx_q - x_q;
    assign gt = 13'(h_q) * 13'(h_q) + 13'(dx) * 13'(dx) > 13'(r_q) * 13'(r_q);

    terrain_col_mask #(.ROWS(NROWS)) u_mask (.cy_i(cy_q), .h_i(h_q), .mask_o(mask));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (lo > hi) ? S_DONE : S_RD;
            S_RD:    state_d = S_WT;
            S_WT:    state_d = S_SRCH;
            S_SRCH:  if (!gt) state_d = S_WR;
            S_WR:    state_d = (x_q == hi_q) ? S_DONE : S_RD;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef TERRAIN_CRATER_COUNT_EN
    logic [15:0] cnt_q;
    assign cleared_count = cnt_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            hi_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            r_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            wr_q    <= '0;
`ifdef TERRAIN_CRATER_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start) begin
                    cx_q  <= center_x;
                    cy_q  <= center_y;
                    r_q   <= radius;
                    x_q   <= lo[9:0];
                    hi_q  <= hi[9:0];
`ifdef TERRAIN_CRATER_COUNT_EN
                    cnt_q <= '0;
`endif
                end
                S_WT: begin
                    col_q <= rd_data;
                    h_q   <= r_q;
                end
                S_SRCH: if (gt) h_q <= h_q - 6'd1; else wr_q <= col_q & ~mask;
                S_WR: begin
`ifdef TERRAIN_CRATER_COUNT_EN
                    cnt_q <= cnt_q + 16'($countones(col_q & mask));
`endif
                    if (x_q != hi_q) x_q <= x_q + 10'd1;
                end
                default: ;
            endcase
        end
    end

    assign rd_addr = x_q;
    assign wr_addr = x_q;
    assign wr_data = wr_q;
    assign we      = (state_q == S_WR);
    assign done    = (state_q == S_DONE);
    assign busy    = (state_q != S_IDLE);
endmodule
